// File: rtl/trap_ctrl_if.sv
// Commit request, flush handshake, redirect/CSR-write strobes and CSR read-back
// state exchanged between the trap controller and the core.
interface trap_ctrl_if #(
    parameter int XLEN          = 32,
    parameter int NUM_LOCAL_IRQ = 4
);
    logic                      valid;
    logic [XLEN-1:0]           pc;
    logic                      mret;
    logic                      exc_pending;
    logic [3:0]                exc_code;
    logic [XLEN-1:0]           exc_tval;

    logic                      flush_req;
    logic                      flush_ack;
    logic                      busy;

    logic                      trap;
    logic [XLEN-1:0]           trap_pc;
    logic                      csr_we_entry;
    logic                      csr_we_exit;
    logic [XLEN-1:0]           csr_wr_mepc;
    logic [XLEN-1:0]           csr_wr_mtval;
    logic                      csr_wr_mcause_interrupt;
    logic [XLEN-2:0]           csr_wr_mcause_code;
    logic                      csr_wr_mstatus_mie;
    logic                      csr_wr_mstatus_mpie;

    logic [15+NUM_LOCAL_IRQ:0] csr_rd_mip;
    logic                      csr_rd_mstatus_mie;
    logic                      csr_rd_mstatus_mpie;
    logic [15+NUM_LOCAL_IRQ:0] csr_rd_mie;
    logic [XLEN-3:0]           csr_rd_mtvec_base;
    logic [1:0]                csr_rd_mtvec_mode;
    logic [XLEN-1:0]           csr_rd_mepc;

    modport slave (
        input  valid, pc, mret, exc_pending, exc_code, exc_tval, flush_ack,
               csr_rd_mstatus_mie, csr_rd_mstatus_mpie, csr_rd_mie,
               csr_rd_mtvec_base, csr_rd_mtvec_mode, csr_rd_mepc,
        output flush_req, busy, trap, trap_pc, csr_we_entry, csr_we_exit,
               csr_wr_mepc, csr_wr_mtval, csr_wr_mcause_interrupt, csr_wr_mcause_code,
               csr_wr_mstatus_mie, csr_wr_mstatus_mpie, csr_rd_mip
    );

    modport master (
        output valid, pc, mret, exc_pending, exc_code, exc_tval, flush_ack,
               csr_rd_mstatus_mie, csr_rd_mstatus_mpie, csr_rd_mie,
               csr_rd_mtvec_base, csr_rd_mtvec_mode, csr_rd_mepc,
        input  flush_req, busy, trap, trap_pc, csr_we_entry, csr_we_exit,
               csr_wr_mepc, csr_wr_mtval, csr_wr_mcause_interrupt, csr_wr_mcause_code,
               csr_wr_mstatus_mie, csr_wr_mstatus_mpie, csr_rd_mip
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: prioritises interrupts, exceptions and mret,
// drains the pipeline via flush handshake, then issues a one-cycle redirect.
module trap_ctrl #(
    parameter int          XLEN          = 32,
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter int unsigned LOCAL_EDGE    = 0,
    parameter int          SYNC_STAGES   = 2,
    parameter bit          VECTORED_EN   = 1'b1
) (
    input  logic                                               clk,
    input  logic                                               rst_b,
    input  logic                                               irq_sw,
    input  logic                                               irq_timer,
    input  logic                                               irq_ext,
    input  logic [((NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1)-1:0] irq_local,
    trap_ctrl_if.slave                                         bus
);
    localparam int LOC_W = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1;
    localparam int NIRQ  = 3 + LOC_W;
    localparam int MIP_W = 16 + NUM_LOCAL_IRQ;
    localparam logic [LOC_W-1:0] EDGE_MASK = LOC_W'(LOCAL_EDGE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              accept;
    logic              redirect;

    logic [NIRQ-1:0]   irq_raw;
    logic [NIRQ-1:0]   irq_sync;
    logic [LOC_W-1:0]  loc_sync;
    logic [LOC_W-1:0]  loc_prev;
    logic [LOC_W-1:0]  loc_edge_pend;
    logic [LOC_W-1:0]  loc_pend;
    logic [LOC_W-1:0]  loc_clr;
    logic [MIP_W-1:0]  mip;
    logic [MIP_W-1:0]  irq_active;
    logic              irq_take;

    logic              exit_q;
    logic              intr_q;
    logic [4:0]        cause_q;
    logic [XLEN-1:0]   mepc_q;
    logic [XLEN-1:0]   tval_q;

    logic              req_exit;
    logic [4:0]        req_cause;
    logic [XLEN-1:0]   req_tval;
    logic [XLEN-1:0]   tvec_base;
    logic [XLEN-1:0]   vec_off;
    logic [XLEN-1:0]   target_pc;

    // Fixed interrupt priority: MEI > MSI > MTI > local 0 > ... > local N-1.
    function automatic logic [4:0] irq_cause(input logic [MIP_W-1:0] act);
        logic [4:0] c;
        c = 5'd0;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--)
            if (act[16+i]) c = 5'(16 + i);
        if (act[7])  c = 5'd7;
        if (act[3])  c = 5'd3;
        if (act[11]) c = 5'd11;
        return c;
    endfunction

    assign irq_raw = {irq_local, irq_ext, irq_timer, irq_sw};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign irq_sync = irq_raw;
        end else begin : g_sync
            logic [NIRQ-1:0] sync_p [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
                end else begin
                    sync_p[0] <= irq_raw;
                    for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
                end
            end
            assign irq_sync = sync_p[SYNC_STAGES-1];
        end
    endgenerate

    assign loc_sync = irq_sync[NIRQ-1:3];

    // Edge lines: a new rising edge wins over a coincident clear.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            loc_prev      <= '0;
            loc_edge_pend <= '0;
        end else begin
            loc_prev      <= loc_sync;
            loc_edge_pend <= EDGE_MASK & ((loc_edge_pend & ~loc_clr) | (loc_sync & ~loc_prev));
        end
    end

    always_comb begin
        loc_clr = '0;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++)
            loc_clr[i] = redirect && !exit_q && intr_q && (cause_q == 5'(16 + i));
    end

    assign loc_pend = (EDGE_MASK & loc_edge_pend) | (~EDGE_MASK & loc_sync);

    always_comb begin
        mip     = '0;
        mip[3]  = irq_sync[0];
        mip[7]  = irq_sync[1];
        mip[11] = irq_sync[2];
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip[16+i] = loc_pend[i];
    end

    assign irq_active = mip & bus.csr_rd_mie;
    assign irq_take   = bus.csr_rd_mstatus_mie && (|irq_active);

    // Request decode: interrupt beats exception beats mret.
    assign req_exit  = !irq_take && !bus.exc_pending;
    assign req_cause = irq_take ? irq_cause(irq_active)
                     : (bus.exc_pending ? {1'b0, bus.exc_code} : 5'd0);
    assign req_tval  = (!irq_take && bus.exc_pending) ? bus.exc_tval : '0;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid && (irq_take || bus.exc_pending || bus.mret)) begin
                    accept  = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.flush_ack) state_d = REDIRECT;
            end
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            exit_q  <= 1'b0;
            intr_q  <= 1'b0;
            cause_q <= '0;
            mepc_q  <= '0;
            tval_q  <= '0;
        end else if (accept) begin
            exit_q  <= req_exit;
            intr_q  <= irq_take;
            cause_q <= req_cause;
            mepc_q  <= bus.pc;
            tval_q  <= req_tval;
        end
    end

    assign redirect  = (state_q == REDIRECT);
    assign tvec_base = {bus.csr_rd_mtvec_base, 2'b00};
    assign vec_off   = (VECTORED_EN && (bus.csr_rd_mtvec_mode == 2'b01) && intr_q)
                     ? XLEN'({cause_q, 2'b00}) : '0;
    assign target_pc = exit_q ? bus.csr_rd_mepc : (tvec_base + vec_off);

    assign bus.flush_req               = (state_q == DRAIN);
    assign bus.busy                    = (state_q != IDLE);
    assign bus.trap                    = redirect;
    assign bus.trap_pc                 = redirect ? target_pc : '0;
    assign bus.csr_we_entry            = redirect && !exit_q;
    assign bus.csr_we_exit             = redirect && exit_q;
    assign bus.csr_wr_mepc             = mepc_q;
    assign bus.csr_wr_mtval            = tval_q;
    assign bus.csr_wr_mcause_interrupt = intr_q;
    assign bus.csr_wr_mcause_code      = (XLEN-1)'(cause_q);
    assign bus.csr_wr_mstatus_mie      = redirect && exit_q && bus.csr_rd_mstatus_mpie;
    assign bus.csr_wr_mstatus_mpie     = redirect && (exit_q || bus.csr_rd_mstatus_mie);
    assign bus.csr_rd_mip              = mip;
endmodule

// File: tb/tb_trap_ctrl.sv
// Randomised scoreboard bench for trap_ctrl with a cause/priority reference model.
module tb_trap_ctrl;
    localparam int XLEN = 32;
    localparam int NL   = 4;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          irq_sw, irq_timer, irq_ext;
    logic [NL-1:0] irq_local;

    trap_ctrl_if #(.XLEN(XLEN), .NUM_LOCAL_IRQ(NL)) bus ();

    trap_ctrl #(
        .XLEN(XLEN), .NUM_LOCAL_IRQ(NL), .LOCAL_EDGE(1),
        .SYNC_STAGES(SYNC), .VECTORED_EN(1'b1)
    ) dut (
        .clk(clk), .rst_b(rst_b), .irq_sw(irq_sw), .irq_timer(irq_timer),
        .irq_ext(irq_ext), .irq_local(irq_local), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] trap_pc;
        logic        exit;
        logic [31:0] mepc;
        logic [31:0] mtval;
        logic        intr;
        logic [4:0]  code;
        logic        mie;
        logic        mpie;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        me;
    int          n_chk  = 0;
    int          n_fail = 0;
    logic        edge_flag = 1'b0;
    logic [31:0] req_pc, req_tval;
    logic        req_mret, req_exc;
    logic [3:0]  req_code;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [19:0] model_mip();
        logic [19:0] m;
        m        = '0;
        m[3]     = irq_sw;
        m[7]     = irq_timer;
        m[11]    = irq_ext;
        m[16]    = edge_flag;
        m[19:17] = irq_local[3:1];
        return m;
    endfunction

    function automatic int pick_irq(input logic [19:0] en);
        int order [7] = '{11, 3, 7, 16, 17, 18, 19};
        int r = -1;
        for (int k = 0; k < 7; k++)
            if (r < 0 && en[order[k]]) r = order[k];
        return r;
    endfunction

    task automatic set_csr(input logic [29:0] base, input logic [1:0] mode, input logic smie,
                           input logic smpie, input logic [19:0] mie, input logic [31:0] mepc);
        bus.csr_rd_mtvec_base   = base;
        bus.csr_rd_mtvec_mode   = mode;
        bus.csr_rd_mstatus_mie  = smie;
        bus.csr_rd_mstatus_mpie = smpie;
        bus.csr_rd_mie          = mie;
        bus.csr_rd_mepc         = mepc;
    endtask

    task automatic set_irq(input logic sw, input logic tm, input logic ext, input logic [2:0] loc);
        irq_sw    = sw;
        irq_timer = tm;
        irq_ext   = ext;
        irq_local = {loc, 1'b0};
    endtask

    task automatic set_req(input logic [31:0] pc, input logic mret, input logic exc,
                           input logic [3:0] code, input logic [31:0] tval);
        req_pc = pc; req_mret = mret; req_exc = exc; req_code = code; req_tval = tval;
    endtask

    // Settle the irq lines, check mip, then issue one commit request and walk the handshake.
    task automatic run_case(input bit pulse, input int ack_dly);
        exp_t        e;
        logic [19:0] en;
        int          c;
        bit          have;
        if (pulse) begin
            irq_local[0] = 1'b1;
            tick();
            irq_local[0] = 1'b0;
            edge_flag    = 1'b1;
        end
        repeat (SYNC + 3) begin
            bus.flush_ack = 1'($urandom);
            tick();
        end
        bus.flush_ack = 1'b0;
        @(negedge clk);
        check("mip", 32'(bus.csr_rd_mip), 32'(model_mip()));
        check("idle_busy", 32'(bus.busy), 32'd0);

        en   = model_mip() & bus.csr_rd_mie;
        have = 1'b1;
        c    = -1;
        e    = '{default: '0};
        if (bus.csr_rd_mstatus_mie && en != 0) begin
            c = pick_irq(en);
            e.intr = 1'b1; e.code = 5'(c); e.mepc = req_pc; e.mtval = 32'd0;
        end else if (req_exc) begin
            e.code = {1'b0, req_code}; e.mepc = req_pc; e.mtval = req_tval;
        end else if (req_mret) begin
            e.exit = 1'b1;
        end else begin
            have = 1'b0;
        end
        if (e.exit) begin
            e.trap_pc = bus.csr_rd_mepc;
            e.mie     = bus.csr_rd_mstatus_mpie;
            e.mpie    = 1'b1;
        end else begin
            e.trap_pc = {bus.csr_rd_mtvec_base, 2'b00};
            if (e.intr && bus.csr_rd_mtvec_mode == 2'b01) e.trap_pc = e.trap_pc + 32'(c) * 4;
            e.mie  = 1'b0;
            e.mpie = bus.csr_rd_mstatus_mie;
            if (e.intr && c == 16) edge_flag = 1'b0;
        end

        bus.valid = 1'b1; bus.pc = req_pc; bus.mret = req_mret;
        bus.exc_pending = req_exc; bus.exc_code = req_code; bus.exc_tval = req_tval;
        tick();
        bus.valid = 1'b0; bus.mret = 1'b0; bus.exc_pending = 1'b0;
        bus.pc = 32'($urandom); bus.exc_tval = 32'($urandom);
        if (have) begin
            exp_q.push_back(e);
            @(negedge clk);
            check("flush_req_rise", 32'(bus.flush_req), 32'd1);
            tick();
            repeat (ack_dly - 1) tick();
            bus.flush_ack = 1'b1;
            tick();
            bus.flush_ack = 1'b0;
            @(negedge clk);
            check("trap_latency", 32'(bus.trap), 32'd1);
            tick();
            @(negedge clk);
            check("back_idle", 32'(bus.busy), 32'd0);
        end else begin
            @(negedge clk);
            check("no_request_busy", 32'(bus.busy), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_b) begin
            if (bus.trap) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_trap: trap_pc 0x%08h with no request outstanding", bus.trap_pc);
                end else begin
                    me = exp_q.pop_front();
                    check("trap_pc", bus.trap_pc, me.trap_pc);
                    check("we_entry", 32'(bus.csr_we_entry), 32'(!me.exit));
                    check("we_exit", 32'(bus.csr_we_exit), 32'(me.exit));
                    check("wr_mie", 32'(bus.csr_wr_mstatus_mie), 32'(me.mie));
                    check("wr_mpie", 32'(bus.csr_wr_mstatus_mpie), 32'(me.mpie));
                    if (!me.exit) begin
                        check("wr_mepc", bus.csr_wr_mepc, me.mepc);
                        check("wr_mtval", bus.csr_wr_mtval, me.mtval);
                        check("mcause_int", 32'(bus.csr_wr_mcause_interrupt), 32'(me.intr));
                        check("mcause_code", 32'(bus.csr_wr_mcause_code), 32'(me.code));
                    end
                end
            end else begin
                check("strobes_quiet", {30'd0, bus.csr_we_entry, bus.csr_we_exit}, 32'd0);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0;
        bus.valid = 1'b0; bus.pc = '0; bus.mret = 1'b0; bus.exc_pending = 1'b0;
        bus.exc_code = '0; bus.exc_tval = '0; bus.flush_ack = 1'b0;
        set_csr(30'd0, 2'd0, 1'b0, 1'b0, 20'd0, 32'd0);
        set_irq(1'b0, 1'b0, 1'b0, 3'd0);
        set_req(32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flush_req", 32'(bus.flush_req), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_trap", 32'(bus.trap), 32'd0);
        check("rst_trap_pc", bus.trap_pc, 32'd0);
        check("rst_we", {30'd0, bus.csr_we_entry, bus.csr_we_exit}, 32'd0);
        check("rst_mepc", bus.csr_wr_mepc, 32'd0);
        check("rst_mip", 32'(bus.csr_rd_mip), 32'd0);
        rst_b = 1'b1;
        tick();

        // Illegal instruction, direct mode
        set_csr(30'h100, 2'd0, 1'b1, 1'b0, 20'd0, 32'd0);
        set_req(32'h80, 1'b0, 1'b1, 4'd2, 32'hDEAD);
        run_case(1'b0, 1);
        // Vectored timer interrupt
        set_csr(30'h100, 2'd1, 1'b1, 1'b0, 20'h00080, 32'd0);
        set_irq(1'b0, 1'b1, 1'b0, 3'd0);
        set_req(32'h1234, 1'b0, 1'b0, 4'd0, 32'd0);
        run_case(1'b0, 2);
        // Simultaneous ext, sw, local 2; then ext drops
        set_csr(30'h200, 2'd0, 1'b1, 1'b0, 20'h40808, 32'd0);
        set_irq(1'b1, 1'b0, 1'b1, 3'b010);
        run_case(1'b0, 1);
        set_irq(1'b1, 1'b0, 1'b0, 3'b010);
        run_case(1'b0, 3);
        // Edge-triggered local 0: captured while MIE=0, then taken
        set_csr(30'h300, 2'd1, 1'b0, 1'b0, 20'h10000, 32'd0);
        set_irq(1'b0, 1'b0, 1'b0, 3'd0);
        run_case(1'b1, 1);
        run_case(1'b0, 1);
        set_csr(30'h300, 2'd1, 1'b1, 1'b0, 20'h10000, 32'd0);
        run_case(1'b0, 1);
        set_csr(30'h300, 2'd1, 1'b0, 1'b0, 20'h10000, 32'd0);
        run_case(1'b0, 1);
        // Interrupt beats exception and mret; then a lone mret
        set_csr(30'h100, 2'd0, 1'b1, 1'b0, 20'h00800, 32'h2000);
        set_irq(1'b0, 1'b0, 1'b1, 3'd0);
        set_req(32'h500, 1'b1, 1'b1, 4'd5, 32'h77);
        run_case(1'b0, 1);
        set_irq(1'b0, 1'b0, 1'b0, 3'd0);
        set_csr(30'h100, 2'd0, 1'b0, 1'b1, 20'h00800, 32'h2000);
        set_req(32'h600, 1'b1, 1'b0, 4'd0, 32'd0);
        run_case(1'b0, 2);

        // Reset during DRAIN aborts without a redirect
        set_req(32'h700, 1'b0, 1'b1, 4'd3, 32'h11);
        @(negedge clk);
        bus.valid = 1'b1; bus.pc = req_pc; bus.exc_pending = 1'b1;
        bus.exc_code = req_code; bus.exc_tval = req_tval;
        tick();
        bus.valid = 1'b0; bus.exc_pending = 1'b0;
        @(negedge clk);
        check("abort_flush_req_before", 32'(bus.flush_req), 32'd1);
        #1 rst_b = 1'b0;
        #1;
        check("abort_flush_req", 32'(bus.flush_req), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_trap", 32'(bus.trap), 32'd0);
        edge_flag = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (6) begin
            bus.flush_ack = 1'b1;
            tick();
        end
        bus.flush_ack = 1'b0;
        @(negedge clk);
        check("post_abort_busy", 32'(bus.busy), 32'd0);

        for (int n = 0; n < 150; n++) begin
            set_csr(30'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                    20'($urandom), $urandom & 32'hFFFF_FFFC);
            set_irq(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0),
                    {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0)});
            set_req($urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom), 4'($urandom),
                    32'($urandom));
            run_case(($urandom_range(0, 3) == 0), $urandom_range(1, 4));
        end

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
